// File: rtl/keen_register_file_mp.sv
// Multi-ported register file with optional zero register, write-to-read bypass and sequential post-reset clear.
// Reads return one cycle after the request; reads and writes are ignored while ready is low.
module keen_register_file_mp #(
  parameter int REGISTERS     = 32,
  parameter int XLEN          = 32,
  parameter int READS         = 2,
  parameter int WRITES        = 1,
  parameter int ZERO_REGISTER = 1,
  parameter int BYPASS        = 1,
  parameter int SEQ_CLEAR     = 0,
  localparam int AW           = $clog2(REGISTERS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [READS*AW-1:0]     read_addresses,
  input  logic [READS-1:0]        read_enables,
  output logic [READS*XLEN-1:0]   read_data,
  output logic [READS-1:0]        read_valid,
  input  logic [WRITES*AW-1:0]    write_addresses,
  input  logic [WRITES*XLEN-1:0]  write_data,
  input  logic [WRITES-1:0]       write_enables,
  output logic                    ready
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        w_clr_en;
  logic [AW-1:0]               r_ptr;
  logic                        r_ready;
  logic [XLEN-1:0]             r_regs [REGISTERS];
  logic [WRITES-1:0]           w_wr_ok;
  logic [READS-1:0][XLEN-1:0]  w_rd_dat;
  logic [READS*XLEN-1:0]       r_rd_dat;
  logic [READS-1:0]            r_rd_vld;

  // Writable/readable storage: in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < REGISTERS) && !((ZERO_REGISTER != 0) && (a == '0));
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_clr_en    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_en = 1'b1;
        if (r_ptr == AW'(REGISTERS - 1)) w_state_nxt = S_RUN;
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Ready is registered so it stays low through the reset cycle in both clear modes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= (SEQ_CLEAR != 0) ? S_CLEAR : S_RUN;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= (r_state == S_CLEAR) ? r_ptr + AW'(1) : '0;
      r_ready <= (w_state_nxt == S_RUN);
    end
  end

  always_comb begin
    for (int j = 0; j < WRITES; j++) begin
      w_wr_ok[j] = r_ready && write_enables[j] && addr_ok(write_addresses[j*AW +: AW]);
    end
  end

  // Later ports are assigned last, so the highest-numbered port wins an address clash.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (SEQ_CLEAR == 0) begin
        for (int k = 0; k < REGISTERS; k++) r_regs[k] <= '0;
      end
    end else if (w_clr_en) begin
      r_regs[r_ptr] <= '0;
    end else begin
      for (int j = 0; j < WRITES; j++) begin
        if (w_wr_ok[j]) r_regs[write_addresses[j*AW +: AW]] <= write_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < READS; i++) begin
      w_rd_dat[i] = '0;
      if (addr_ok(read_addresses[i*AW +: AW])) w_rd_dat[i] = r_regs[read_addresses[i*AW +: AW]];
      if (BYPASS != 0) begin
        for (int j = 0; j < WRITES; j++) begin
          if (w_wr_ok[j] && (write_addresses[j*AW +: AW] == read_addresses[i*AW +: AW]))
            w_rd_dat[i] = write_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_dat <= '0;
      r_rd_vld <= '0;
    end else begin
      for (int i = 0; i < READS; i++) begin
        if (read_enables[i] && r_ready) begin
          r_rd_dat[i*XLEN +: XLEN] <= w_rd_dat[i];
          r_rd_vld[i]              <= 1'b1;
        end else begin
          r_rd_vld[i]              <= 1'b0;
        end
      end
    end
  end

  assign read_data  = r_rd_dat;
  assign read_valid = r_rd_vld;
  assign ready      = r_ready;

endmodule

// File: tb/tb_keen_register_file_mp.sv
// Scoreboard bench for keen_register_file_mp: instance 0 uses sequential clear with bypass,
// instance 1 uses 24 registers, reset-cycle clear and no bypass.
module tb_keen_register_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst   [2];
  logic [9:0]  raddr [2];
  logic [1:0]  ren   [2];
  logic [63:0] rdata [2];
  logic [1:0]  rvld  [2];
  logic [9:0]  waddr [2];
  logic [63:0] wdata [2];
  logic [1:0]  wen   [2];
  logic        rdy   [2];

  keen_register_file_mp #(
    .REGISTERS(32), .XLEN(32), .READS(2), .WRITES(2),
    .ZERO_REGISTER(1), .BYPASS(1), .SEQ_CLEAR(1)
  ) u_a (
    .clk(clk), .reset(rst[0]),
    .read_addresses(raddr[0]), .read_enables(ren[0]),
    .read_data(rdata[0]), .read_valid(rvld[0]),
    .write_addresses(waddr[0]), .write_data(wdata[0]),
    .write_enables(wen[0]), .ready(rdy[0])
  );

  keen_register_file_mp #(
    .REGISTERS(24), .XLEN(32), .READS(2), .WRITES(2),
    .ZERO_REGISTER(1), .BYPASS(0), .SEQ_CLEAR(0)
  ) u_b (
    .clk(clk), .reset(rst[1]),
    .read_addresses(raddr[1]), .read_enables(ren[1]),
    .read_data(rdata[1]), .read_valid(rvld[1]),
    .write_addresses(waddr[1]), .write_data(wdata[1]),
    .write_enables(wen[1]), .ready(rdy[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Expected read responses, one queue per (instance, port); entry = {due cycle, data}.
  logic [63:0] q0[$], q1[$], q2[$], q3[$];

  function automatic void push_q(input int k, input logic [63:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endfunction

  function automatic logic [63:0] pop_q(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  function automatic int size_q(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; read expectations are due at the edge that samples them.
  task automatic op(input int d, input logic [1:0] re,
                    input logic [4:0] ra0, input logic [4:0] ra1,
                    input logic [31:0] e0, input logic [31:0] e1,
                    input logic [1:0] we,
                    input logic [4:0] wa0, input logic [31:0] wd0,
                    input logic [4:0] wa1, input logic [31:0] wd1);
    ren[d]   = re;
    raddr[d] = {ra1, ra0};
    wen[d]   = we;
    waddr[d] = {wa1, wa0};
    wdata[d] = {wd1, wd0};
    if (re[0]) push_q(d*2,     {32'(cyc + 1), e0});
    if (re[1]) push_q(d*2 + 1, {32'(cyc + 1), e1});
    step();
    ren[d] = 2'b00;
    wen[d] = 2'b00;
  endtask

  task automatic wait_ready(input int d, input int n0, input int exp, input string nm);
    int n;
    n = n0;
    while (rdy[d] !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check(nm, 64'(n), 64'(exp));
  endtask

  logic [63:0] mon_e;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (rvld[d][p] === 1'b1) begin
          if (size_q(d*2 + p) == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_valid dut%0d port%0d: got data %h, no read outstanding",
                     d, p, rdata[d][p*32 +: 32]);
          end else begin
            mon_e = pop_q(d*2 + p);
            check($sformatf("rd_dut%0d_p%0d", d, p), {32'(cyc), rdata[d][p*32 +: 32]}, mon_e);
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; ren[d] = '0; raddr[d] = '0;
      wen[d] = '0; waddr[d] = '0; wdata[d] = '0;
    end

    // Instance 0: reset held 3 cycles, then 32-cycle sequential clear.
    repeat (3) step();
    check("a_rst_ready", 64'(rdy[0]), 64'(0));
    check("a_rst_valid", 64'(rvld[0]), 64'(0));
    check("a_rst_rdata", rdata[0], 64'(0));
    rst[0] = 1'b0;
    wait_ready(0, 0, 32, "a_clear_len");
    for (int k = 0; k < 16; k++) op(0, 2'b11, 5'(2*k), 5'(2*k+1), '0, '0, 2'b00, '0, '0, '0, '0);

    // Write then read on both ports.
    op(0, 2'b00, '0, '0, '0, '0, 2'b01, 5'd5, 32'hDEADBEEF, '0, '0);
    op(0, 2'b11, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, '0, '0, '0, '0);
    check("a_rvld_both", 64'(rvld[0]), 64'(2'b11));

    // Same-cycle bypass, then a normal read of the committed value.
    op(0, 2'b11, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 2'b01, 5'd7, 32'h12345678, '0, '0);
    op(0, 2'b01, 5'd7, '0, 32'h12345678, '0, 2'b00, '0, '0, '0, '0);

    // Write-port priority, zero register, independent writes, bypass priority.
    op(0, 2'b00, '0, '0, '0, '0, 2'b11, 5'd3, 32'h1111, 5'd3, 32'h2222);
    op(0, 2'b11, 5'd3, 5'd5, 32'h2222, 32'hDEADBEEF, 2'b00, '0, '0, '0, '0);
    op(0, 2'b01, 5'd0, '0, '0, '0, 2'b10, '0, '0, 5'd0, 32'hFFFFFFFF);
    op(0, 2'b01, 5'd0, '0, '0, '0, 2'b00, '0, '0, '0, '0);
    op(0, 2'b00, '0, '0, '0, '0, 2'b11, 5'd8, 32'hAAAA0008, 5'd9, 32'hBBBB0009);
    op(0, 2'b11, 5'd8, 5'd9, 32'hAAAA0008, 32'hBBBB0009, 2'b00, '0, '0, '0, '0);
    op(0, 2'b11, 5'd10, 5'd10, 32'h40, 32'h40, 2'b11, 5'd10, 32'h30, 5'd10, 32'h40);
    op(0, 2'b01, 5'd10, '0, 32'h40, '0, 2'b00, '0, '0, '0, '0);

    // Fill, reset, interrupt the clear at ptr 10, write during clear, verify full clear.
    for (int k = 1; k < 32; k++) op(0, 2'b00, '0, '0, '0, '0, 2'b01, 5'(k), 32'(256 + k), '0, '0);
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    repeat (10) step();
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    repeat (5) step();
    op(0, 2'b00, '0, '0, '0, '0, 2'b11, 5'd2, 32'hBAD0, 5'd1, 32'hBAD1);
    wait_ready(0, 6, 32, "a_clear_restart");
    for (int k = 0; k < 16; k++) op(0, 2'b11, 5'(2*k), 5'(2*k+1), '0, '0, 2'b00, '0, '0, '0, '0);

    // Instance 1: reset-cycle clear, no bypass, 24 registers.
    check("b_rst_ready", 64'(rdy[1]), 64'(0));
    check("b_rst_valid", 64'(rvld[1]), 64'(0));
    check("b_rst_rdata", rdata[1], 64'(0));
    rst[1] = 1'b0;
    wait_ready(1, 0, 1, "b_ready_len");
    op(1, 2'b01, 5'd7, '0, '0, '0, 2'b01, 5'd7, 32'h12345678, '0, '0);
    op(1, 2'b01, 5'd7, '0, 32'h12345678, '0, 2'b00, '0, '0, '0, '0);
    op(1, 2'b10, '0, 5'd30, '0, '0, 2'b01, 5'd30, 32'hCAFEF00D, '0, '0);
    op(1, 2'b11, 5'd30, 5'd6, '0, '0, 2'b00, '0, '0, '0, '0);
    op(1, 2'b11, 5'd14, 5'd0, '0, '0, 2'b10, '0, '0, 5'd23, 32'h55);
    op(1, 2'b11, 5'd23, 5'd7, 32'h55, 32'h12345678, 2'b00, '0, '0, '0, '0);
    op(1, 2'b00, '0, '0, '0, '0, 2'b00, '0, '0, '0, '0);
    check("b_hold_valid", 64'(rvld[1]), 64'(0));
    check("b_hold_rdata", rdata[1], {32'h12345678, 32'h55});
    rst[1] = 1'b1; step();
    check("b_rst2_ready", 64'(rdy[1]), 64'(0));
    check("b_rst2_rdata", rdata[1], 64'(0));
    rst[1] = 1'b0;
    wait_ready(1, 0, 1, "b_ready_len2");
    op(1, 2'b11, 5'd7, 5'd23, '0, '0, 2'b00, '0, '0, '0, '0);

    repeat (2) step();
    check("sb_drain", 64'(q0.size() + q1.size() + q2.size() + q3.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
